scan_decoder: RTL and testbench

Parametrised one-hot decoder with registered outputs and a built-in scan sequencer. It drives multiplexed display rows/digits and other time-shared select lines in the tetris datapath. In direct mode it decodes `Sel` like a plain decoder, one cycle late. In scan mode it walks the channels enabled in `ChanMask`, holding each for a programmable dwell time, with optional blanking gaps and a frame-start pulse.

---
 rtl/scan_decoder_if.sv | 25 ++
 rtl/scan_decoder.sv | 155 +++++++++++++++
 tb/tb_scan_decoder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_decoder_if.sv
// Select/scan bus for scan_decoder: control inputs from the master side,
// registered decoder outputs from the slave (decoder) side.
interface scan_decoder_if #(
  parameter int SEL_WIDTH = 2
);
  localparam int OUT_COUNT = 2 ** SEL_WIDTH;

  logic                 Enable;
  logic                 Mode;
  logic [SEL_WIDTH-1:0] Sel;
  logic [OUT_COUNT-1:0] ChanMask;
  logic [OUT_COUNT-1:0] DecoderOut;
  logic [SEL_WIDTH-1:0] ScanIndex;
  logic                 FrameStart;

  modport master (
    output Enable, Mode, Sel, ChanMask,
    input  DecoderOut, ScanIndex, FrameStart
  );

  modport slave (
    input  Enable, Mode, Sel, ChanMask,
    output DecoderOut, ScanIndex, FrameStart
  );
endinterface

// File: rtl/scan_decoder.sv
// One-hot decoder with registered outputs and a scan sequencer that walks the
// channels enabled in ChanMask with per-channel dwell and optional blanking.
module scan_decoder #(
  parameter int SEL_WIDTH = 2,
  parameter int DWELL     = 4,
  parameter int BLANK     = 1
) (
  input logic           Clock,
  input logic           Reset_n,
  scan_decoder_if.slave bus
);
  localparam int OUT_COUNT = 2 ** SEL_WIDTH;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIRECT,
    S_DRIVE,
    S_BLANK
  } state_e;

  state_e               state_q, state_d;
  logic [OUT_COUNT-1:0] dec_q, dec_d;
  logic [SEL_WIDTH-1:0] idx_q, idx_d;
  logic                 fs_q, fs_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [BW-1:0]        blank_q, blank_d;

  logic                 mask_any;
  logic                 low_found;
  logic                 nxt_found;
  logic                 nxt_wrap;
  logic [SEL_WIDTH-1:0] low_idx;
  logic [SEL_WIDTH-1:0] nxt_idx;
  logic [SEL_WIDTH-1:0] cand;
  logic                 start;
  logic                 step;

  function automatic logic [OUT_COUNT-1:0] onehot(input logic [SEL_WIDTH-1:0] i);
    logic [OUT_COUNT-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Lowest enabled channel, and next enabled channel strictly above idx_q
  // (the index sum wraps naturally, giving the circular search).
  always_comb begin
    mask_any  = |bus.ChanMask;
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < OUT_COUNT; i++) begin
      if (!low_found && bus.ChanMask[i]) begin
        low_idx   = SEL_WIDTH'(i);
        low_found = 1'b1;
      end
    end
    nxt_idx   = idx_q;
    nxt_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= OUT_COUNT; k++) begin
      cand = idx_q + SEL_WIDTH'(k);
      if (!nxt_found && bus.ChanMask[cand]) begin
        nxt_idx   = cand;
        nxt_found = 1'b1;
      end
    end
    nxt_wrap = (nxt_idx <= idx_q);
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    idx_d   = idx_q;
    fs_d    = 1'b0;
    dwell_d = dwell_q;
    blank_d = blank_q;
    start   = 1'b0;
    step    = 1'b0;

    if (!bus.Enable) begin
      state_d = S_IDLE;
      dec_d   = '0;
      dwell_d = '0;
      blank_d = '0;
    end else if (!bus.Mode) begin
      state_d = S_DIRECT;
      dec_d   = onehot(bus.Sel);
      idx_d   = bus.Sel;
    end else begin
      unique case (state_q)
        S_IDLE, S_DIRECT: start = 1'b1;
        S_DRIVE: begin
          if (dwell_q != '0) begin
            dwell_d = dwell_q - DW'(1);
          end else if (BLANK > 0) begin
            state_d = S_BLANK;
            dec_d   = '0;
            blank_d = BLANK_LOAD;
          end else begin
            step = 1'b1;
          end
        end
        S_BLANK: begin
          if (blank_q != '0) blank_d = blank_q - BW'(1);
          else               step    = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase

      // An empty mask parks in IDLE, so a later nonzero mask re-enters the scan.
      if ((start || step) && !mask_any) begin
        state_d = S_IDLE;
        dec_d   = '0;
      end else if (start) begin
        state_d = S_DRIVE;
        idx_d   = low_idx;
        dec_d   = onehot(low_idx);
        dwell_d = DWELL_LOAD;
        fs_d    = 1'b1;
      end else if (step) begin
        state_d = S_DRIVE;
        idx_d   = nxt_idx;
        dec_d   = onehot(nxt_idx);
        dwell_d = DWELL_LOAD;
        fs_d    = nxt_wrap;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      dec_q   <= '0;
      idx_q   <= '0;
      fs_q    <= 1'b0;
      dwell_q <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      idx_q   <= idx_d;
      fs_q    <= fs_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
    end
  end

  assign bus.DecoderOut = dec_q;
  assign bus.ScanIndex  = idx_q;
  assign bus.FrameStart = fs_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: four parameterisations driven side by side and
// checked against a step-position reference model plus fixed expected patterns.
module tb_scan_decoder;
  logic Clock;
  logic Reset_n;
  int   total;
  int   bad;

  typedef struct {
    bit          active;
    int          cur;
    int          pos;
    logic [31:0] out;
    int          idx;
    bit          fs;
  } mdl_t;

  mdl_t ma, mb, mc, md;

  scan_decoder_if #(.SEL_WIDTH(2)) ifa ();
  scan_decoder_if #(.SEL_WIDTH(2)) ifb ();
  scan_decoder_if #(.SEL_WIDTH(3)) ifc ();
  scan_decoder_if #(.SEL_WIDTH(5)) ifd ();

  scan_decoder #(.SEL_WIDTH(2), .DWELL(4), .BLANK(1)) u_a (.Clock(Clock), .Reset_n(Reset_n), .bus(ifa));
  scan_decoder #(.SEL_WIDTH(2), .DWELL(2), .BLANK(0)) u_b (.Clock(Clock), .Reset_n(Reset_n), .bus(ifb));
  scan_decoder #(.SEL_WIDTH(3), .DWELL(3), .BLANK(2)) u_c (.Clock(Clock), .Reset_n(Reset_n), .bus(ifc));
  scan_decoder #(.SEL_WIDTH(5), .DWELL(1), .BLANK(1)) u_d (.Clock(Clock), .Reset_n(Reset_n), .bus(ifd));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic mdl_t mreset();
    mdl_t r;
    r.active = 0; r.cur = 0; r.pos = 0; r.out = '0; r.idx = 0; r.fs = 0;
    return r;
  endfunction

  // Scan is a sequence of steps; pos counts cycles since the step began.
  function automatic mdl_t mstep(input mdl_t m, input bit rst_n, input bit en, input bit mode,
                                 input int sel, input logic [31:0] mask, input int n,
                                 input int dwell, input int blank);
    mdl_t r;
    int   prev;
    bit   pick;
    bit   entry;
    r = m; r.fs = 0; pick = 0; entry = 0; prev = m.cur;
    if (!rst_n) return mreset();
    if (!en) begin
      r.active = 0; r.out = '0;
    end else if (!mode) begin
      r.active = 0; r.idx = sel; r.out = 32'(1) << sel;
    end else begin
      if (!r.active) begin
        pick = 1; entry = 1;
      end else begin
        r.pos++;
        if (r.pos >= dwell + blank) pick = 1;
      end
      if (pick) begin
        if (mask == '0) begin
          r.active = 0;
        end else begin
          if (entry) begin
            for (int k = 0; k < n; k++) if (mask[k]) begin r.cur = k; break; end
            r.fs = 1;
          end else begin
            for (int k = 1; k <= n; k++) if (mask[(prev + k) % n]) begin r.cur = (prev + k) % n; break; end
            r.fs = (r.cur <= prev);
          end
          r.active = 1; r.pos = 0; r.idx = r.cur;
        end
      end
      r.out = (r.active && r.pos < dwell) ? (32'(1) << r.cur) : '0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge Clock);
    ma = mstep(ma, Reset_n, ifa.Enable, ifa.Mode, int'(ifa.Sel), 32'(ifa.ChanMask), 4, 4, 1);
    mb = mstep(mb, Reset_n, ifb.Enable, ifb.Mode, int'(ifb.Sel), 32'(ifb.ChanMask), 4, 2, 0);
    mc = mstep(mc, Reset_n, ifc.Enable, ifc.Mode, int'(ifc.Sel), 32'(ifc.ChanMask), 8, 3, 2);
    md = mstep(md, Reset_n, ifd.Enable, ifd.Mode, int'(ifd.Sel), 32'(ifd.ChanMask), 32, 1, 1);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    ifa.Enable = 1; ifa.Mode = 1; ifa.Sel = '0; ifa.ChanMask = 4'b1111;
    ifb.Enable = 1; ifb.Mode = 0; ifb.Sel = 2'd3; ifb.ChanMask = '0;
    ifc.Enable = 1; ifc.Mode = 1; ifc.Sel = '0; ifc.ChanMask = 8'hff;
    ifd.Enable = 1; ifd.Mode = 1; ifd.Sel = '0; ifd.ChanMask = '1;
    ma = mreset(); mb = mreset(); mc = mreset(); md = mreset();
    tick(); tick();
    total++; if (ifa.DecoderOut !== 4'b0000) begin bad++; $display("FAIL reset_dec_a: got %b want 0000", ifa.DecoderOut); end
    total++; if (ifa.ScanIndex !== 2'd0) begin bad++; $display("FAIL reset_idx_a: got %0d want 0", ifa.ScanIndex); end
    total++; if (ifa.FrameStart !== 1'b0) begin bad++; $display("FAIL reset_fs_a: got %b want 0", ifa.FrameStart); end
    total++; if (ifb.DecoderOut !== 4'b0000) begin bad++; $display("FAIL reset_dec_b: got %b want 0000", ifb.DecoderOut); end
    total++; if (ifc.DecoderOut !== 8'h00) begin bad++; $display("FAIL reset_dec_c: got %h want 00", ifc.DecoderOut); end
    total++; if (ifd.DecoderOut !== 32'h0) begin bad++; $display("FAIL reset_dec_d: got %h want 0", ifd.DecoderOut); end
    ifa.Enable = 0; ifb.Enable = 0; ifc.Enable = 0; ifd.Enable = 0;
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_direct();
    logic [3:0] exp_dir [4];
    exp_dir = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ifa.Enable = 1; ifa.Mode = 0;
    for (int s = 0; s < 4; s++) begin
      ifa.Sel = 2'(s);
      if (s > 0) begin
        total++; if (ifa.DecoderOut !== exp_dir[s-1]) begin bad++; $display("FAIL direct_latency: got %b want %b", ifa.DecoderOut, exp_dir[s-1]); end
      end
      tick();
      total++; if (ifa.DecoderOut !== exp_dir[s]) begin bad++; $display("FAIL direct_dec: sel %0d got %b want %b", s, ifa.DecoderOut, exp_dir[s]); end
      total++; if (ifa.ScanIndex !== 2'(s)) begin bad++; $display("FAIL direct_idx: got %0d want %0d", ifa.ScanIndex, s); end
      total++; if (ifa.FrameStart !== 1'b0) begin bad++; $display("FAIL direct_fs: got %b want 0", ifa.FrameStart); end
    end
    ifa.Enable = 0;
    tick();
    total++; if (ifa.DecoderOut !== 4'b0000) begin bad++; $display("FAIL direct_disable: got %b want 0000", ifa.DecoderOut); end
    total++; if (ifa.ScanIndex !== 2'd3) begin bad++; $display("FAIL direct_disable_idx: got %0d want 3", ifa.ScanIndex); end
  endtask

  task automatic test_scan_full();
    logic [3:0] e;
    int         ch;
    ifa.ChanMask = 4'b1111; ifa.Mode = 1; ifa.Enable = 1;
    for (int c = 0; c < 60; c++) begin
      tick();
      ch = (c / 5) % 4;
      e  = ((c % 5) < 4) ? 4'(1 << ch) : 4'b0000;
      total++; if (ifa.DecoderOut !== e) begin bad++; $display("FAIL scan_dec: cycle %0d got %b want %b", c, ifa.DecoderOut, e); end
      total++; if (ifa.ScanIndex !== 2'(ch)) begin bad++; $display("FAIL scan_idx: cycle %0d got %0d want %0d", c, ifa.ScanIndex, ch); end
      total++; if (ifa.FrameStart !== ((c % 20) == 0)) begin bad++; $display("FAIL scan_fs: cycle %0d got %b want %b", c, ifa.FrameStart, (c % 20) == 0); end
    end
    ifa.Enable = 0;
    tick();
  endtask

  task automatic test_sparse();
    logic [3:0] e;
    ifb.ChanMask = 4'b1010; ifb.Mode = 1; ifb.Enable = 1;
    for (int c = 0; c < 16; c++) begin
      tick();
      e = ((c % 4) < 2) ? 4'b0010 : 4'b1000;
      total++; if (ifb.DecoderOut !== e) begin bad++; $display("FAIL sparse_dec: cycle %0d got %b want %b", c, ifb.DecoderOut, e); end
      total++; if (ifb.FrameStart !== ((c % 4) == 0)) begin bad++; $display("FAIL sparse_fs: cycle %0d got %b want %b", c, ifb.FrameStart, (c % 4) == 0); end
    end
    ifb.Enable = 0;
    tick();
  endtask

  task automatic test_mask_edges();
    logic [3:0] seq_d [9];
    bit         seq_f [9];
    seq_d = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    seq_f = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    ifa.ChanMask = 4'b1111; ifa.Mode = 1; ifa.Enable = 1;
    tick();
    total++; if (ifa.DecoderOut !== 4'b0001 || ifa.FrameStart !== 1'b1) begin bad++; $display("FAIL edge_entry: got %b/%b want 0001/1", ifa.DecoderOut, ifa.FrameStart); end
    tick();
    ifa.ChanMask = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      tick();
      total++; if (ifa.DecoderOut !== seq_d[c]) begin bad++; $display("FAIL edge_midmask_dec: step %0d got %b want %b", c, ifa.DecoderOut, seq_d[c]); end
      total++; if (ifa.FrameStart !== seq_f[c]) begin bad++; $display("FAIL edge_midmask_fs: step %0d got %b want %b", c, ifa.FrameStart, seq_f[c]); end
    end
    ifa.ChanMask = 4'b0000;
    for (int c = 0; c < 15; c++) begin
      tick();
      total++; if (ifa.DecoderOut !== ((c < 3) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL edge_zero_dec: step %0d got %b", c, ifa.DecoderOut); end
      total++; if (ifa.FrameStart !== 1'b0) begin bad++; $display("FAIL edge_zero_fs: step %0d got %b want 0", c, ifa.FrameStart); end
      total++; if (ifa.ScanIndex !== 2'd2) begin bad++; $display("FAIL edge_zero_idx: step %0d got %0d want 2", c, ifa.ScanIndex); end
    end
    ifa.ChanMask = 4'b0001;
    tick();
    total++; if (ifa.DecoderOut !== 4'b0001 || ifa.FrameStart !== 1'b1) begin bad++; $display("FAIL edge_return: got %b/%b want 0001/1", ifa.DecoderOut, ifa.FrameStart); end
    total++; if (ifa.ScanIndex !== 2'd0) begin bad++; $display("FAIL edge_return_idx: got %0d want 0", ifa.ScanIndex); end
  endtask

  task automatic test_async_reset();
    ifa.ChanMask = 4'b1111;
    for (int c = 0; c < 6; c++) tick();
    total++; if (ifa.DecoderOut !== 4'b0010 || ifa.ScanIndex !== 2'd1) begin bad++; $display("FAIL areset_pre: got %b idx %0d want 0010 idx 1", ifa.DecoderOut, ifa.ScanIndex); end
    #3 Reset_n = 1'b0;
    #1;
    total++; if (ifa.DecoderOut !== 4'b0000) begin bad++; $display("FAIL areset_dec: got %b want 0000", ifa.DecoderOut); end
    total++; if (ifa.ScanIndex !== 2'd0) begin bad++; $display("FAIL areset_idx: got %0d want 0", ifa.ScanIndex); end
    total++; if (ifa.FrameStart !== 1'b0) begin bad++; $display("FAIL areset_fs: got %b want 0", ifa.FrameStart); end
    ma = mreset(); mb = mreset(); mc = mreset(); md = mreset();
    #2 Reset_n = 1'b1;
    tick();
    total++; if (ifa.DecoderOut !== 4'b0001 || ifa.FrameStart !== 1'b1) begin bad++; $display("FAIL areset_restart: got %b/%b want 0001/1", ifa.DecoderOut, ifa.FrameStart); end
    total++; if (ifa.ScanIndex !== 2'd0) begin bad++; $display("FAIL areset_restart_idx: got %0d want 0", ifa.ScanIndex); end
  endtask

  task automatic test_random();
    logic [31:0] rm;
    ifa.Enable = 1; ifa.Mode = 1; ifb.Enable = 1; ifb.Mode = 1;
    ifc.Enable = 1; ifc.Mode = 1; ifd.Enable = 1; ifd.Mode = 1;
    ifb.ChanMask = 4'b0110; ifc.ChanMask = 8'h5a; ifd.ChanMask = 32'h8001_0100;
    for (int c = 0; c < 2000; c++) begin
      ifa.Sel = 2'($urandom); ifb.Sel = 2'($urandom); ifc.Sel = 3'($urandom); ifd.Sel = 5'($urandom);
      if ($urandom_range(0, 15) == 0) ifa.Enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) ifb.Enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) ifc.Enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) ifd.Enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) ifa.Mode = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) ifb.Mode = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) ifc.Mode = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) ifd.Mode = ($urandom_range(0, 3) != 0);
      rm = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 9) == 0) ifa.ChanMask = 4'(rm);
      if ($urandom_range(0, 9) == 0) ifb.ChanMask = 4'(rm >> 4);
      if ($urandom_range(0, 9) == 0) ifc.ChanMask = 8'(rm >> 8);
      if ($urandom_range(0, 9) == 0) ifd.ChanMask = rm;
      tick();
      total++; if (32'(ifa.DecoderOut) !== ma.out || 32'(ifa.ScanIndex) !== 32'(ma.idx) || ifa.FrameStart !== ma.fs) begin bad++; $display("FAIL rand_a: cycle %0d got %b/%0d/%b want %b/%0d/%b", c, ifa.DecoderOut, ifa.ScanIndex, ifa.FrameStart, 4'(ma.out), ma.idx, ma.fs); end
      total++; if (32'(ifb.DecoderOut) !== mb.out || 32'(ifb.ScanIndex) !== 32'(mb.idx) || ifb.FrameStart !== mb.fs) begin bad++; $display("FAIL rand_b: cycle %0d got %b/%0d/%b want %b/%0d/%b", c, ifb.DecoderOut, ifb.ScanIndex, ifb.FrameStart, 4'(mb.out), mb.idx, mb.fs); end
      total++; if (32'(ifc.DecoderOut) !== mc.out || 32'(ifc.ScanIndex) !== 32'(mc.idx) || ifc.FrameStart !== mc.fs) begin bad++; $display("FAIL rand_w3: cycle %0d got %h/%0d/%b want %h/%0d/%b", c, ifc.DecoderOut, ifc.ScanIndex, ifc.FrameStart, 8'(mc.out), mc.idx, mc.fs); end
      total++; if (ifd.DecoderOut !== md.out || 32'(ifd.ScanIndex) !== 32'(md.idx) || ifd.FrameStart !== md.fs) begin bad++; $display("FAIL rand_w5: cycle %0d got %h/%0d/%b want %h/%0d/%b", c, ifd.DecoderOut, ifd.ScanIndex, ifd.FrameStart, md.out, md.idx, md.fs); end
      total++; if (!$onehot0(ifc.DecoderOut) || !$onehot0(ifd.DecoderOut)) begin bad++; $display("FAIL rand_onehot: cycle %0d got %h / %h want at most one bit", c, ifc.DecoderOut, ifd.DecoderOut); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_direct();
    test_scan_full();
    test_sparse();
    test_mask_edges();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
